// File: rtl/genesis_pkg.sv
// rtl/genesis_pkg.sv - Genesis cart header addresses, quirk IDs and lookup helper
package genesis_pkg;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // Word addresses of the serial-number field in the cart header
  localparam logic [ADDR_W-1:0] HDR_ID0 = 25'h182;
  localparam logic [ADDR_W-1:0] HDR_ID1 = 25'h184;
  localparam logic [ADDR_W-1:0] HDR_ID2 = 25'h186;
  localparam logic [ADDR_W-1:0] HDR_ID3 = 25'h188;
  localparam logic [ADDR_W-1:0] HDR_ID4 = 25'h18A;

  // 8-character serial numbers, first character in the top byte
  localparam logic [63:0] ID_SRAM_0   = "T-081276";
  localparam logic [63:0] ID_SRAM_1   = "T-81406 ";
  localparam logic [63:0] ID_SRAM_2   = "T-081586";
  localparam logic [63:0] ID_SRAM_3   = "T-81576 ";
  localparam logic [63:0] ID_SRAM_4   = "T-81476 ";
  localparam logic [63:0] ID_EEPROM_0 = "MK-1215 ";
  localparam logic [63:0] ID_EEPROM_1 = "G-4060  ";
  localparam logic [63:0] ID_EEPROM_2 = "00001211";
  localparam logic [63:0] ID_EEPROM_3 = "MK-1228 ";
  localparam logic [63:0] ID_EEPROM_4 = "G-5538  ";
  localparam logic [63:0] ID_EEPROM_5 = "00004076";
  localparam logic [63:0] ID_EEPROM_6 = "T-12046 ";
  localparam logic [63:0] ID_EEPROM_7 = "T-12053 ";
  localparam logic [63:0] ID_EEPROM_8 = "G-4524  ";
  localparam logic [63:0] ID_FIFO_0   = "T-89016 ";
  localparam logic [63:0] ID_FIFO_1   = "00001009";
  localparam logic [63:0] ID_FIFO_2   = "00004049";
  localparam logic [63:0] ID_ZBUS_0   = "T-103036";

  typedef struct packed {
    logic zbus;
    logic fifo;
    logic eeprom;
    logic sram;
  } quirk_t;

  // Map a complete serial number onto the set of cart quirks it needs
  function automatic quirk_t quirk_lookup(input logic [63:0] id);
    quirk_t q;
    q.sram   = (id == ID_SRAM_0) || (id == ID_SRAM_1) || (id == ID_SRAM_2) ||
               (id == ID_SRAM_3) || (id == ID_SRAM_4);
    q.eeprom = (id == ID_EEPROM_0) || (id == ID_EEPROM_1) || (id == ID_EEPROM_2) ||
               (id == ID_EEPROM_3) || (id == ID_EEPROM_4) || (id == ID_EEPROM_5) ||
               (id == ID_EEPROM_6) || (id == ID_EEPROM_7) || (id == ID_EEPROM_8);
    q.fifo   = (id == ID_FIFO_0) || (id == ID_FIFO_1) || (id == ID_FIFO_2);
    q.zbus   = (id == ID_ZBUS_0);
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = wr_en & ~full;
  assign w_rd    = rd_en & ~empty;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  // Storage array, no reset needed since empty entries are never read out
  always_ff @(posedge clk) begin
    if (w_wr && !clr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - buffers HPS ROM download words into toggle-handshake DDRAM writes
module rom_loader
  import genesis_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_data,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] wraddr,
  output logic [DATA_W-1:0] din,
  output logic              we_req,
  input  logic              we_ack,
  output logic              sram_quirk,
  output logic              eeprom_quirk,
  output logic              fifo_quirk,
  output logic              zbus_quirk,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic               r_dl_prev;
  logic               r_wait;
  logic               r_we_req;
  logic [ADDR_W-1:0]  r_wraddr;
  logic [DATA_W-1:0]  r_din;
  logic               r_overflow;
  logic [55:0]        r_id;
  quirk_t             r_quirk;

  logic               w_dl_rise;
  logic               w_wr_ok;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_next;
  logic [ENTRY_W-1:0] w_head;

  // A write arriving on the restart cycle is discarded along with the old contents
  assign w_dl_rise = ioctl_download & ~r_dl_prev;
  assign w_wr_ok   = ioctl_wr & ioctl_download & ~w_dl_rise;
  assign w_push    = w_wr_ok & ~w_full;
  assign w_drop    = w_wr_ok & w_full;
  assign w_pop     = (r_we_req == we_ack) & ~w_empty & ~w_dl_rise;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .reset   (reset),
    .clr     (w_dl_rise),
    .wr_en   (w_push),
    .wr_data ({ioctl_addr, ioctl_data[7:0], ioctl_data[15:8]}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Occupancy as it will be after this edge, so ioctl_wait tracks it with no extra lag
  always_comb begin
    w_count_next = w_count;
    if (w_dl_rise) w_count_next = '0;
    else           w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  end

  // Download edge detector and registered backpressure
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_prev <= 1'b0;
      r_wait    <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_wait    <= (w_count_next >= CW'(DEPTH - 1));
    end
  end

  // DDRAM request port: launch one write from the FIFO head whenever the last one is acked
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_we_req <= 1'b0;
      r_wraddr <= '0;
      r_din    <= '0;
    end else if (w_dl_rise) begin
      r_we_req <= we_ack;
    end else if (w_pop) begin
      r_wraddr <= w_head[ENTRY_W-1:DATA_W];
      r_din    <= w_head[DATA_W-1:0];
      r_we_req <= ~r_we_req;
    end
  end

  // Sticky record that a write was dropped because the FIFO was full
  always_ff @(posedge clk_sys) begin
    if (reset || w_dl_rise) r_overflow <= 1'b0;
    else if (w_drop)        r_overflow <= 1'b1;
  end

  // Header serial capture and quirk lookup once the last serial byte arrives
  always_ff @(posedge clk_sys) begin
    if (reset || w_dl_rise) begin
      r_id    <= '0;
      r_quirk <= '0;
    end else if (w_push) begin
      case (ioctl_addr)
        HDR_ID0: r_id[55:48] <= ioctl_data[15:8];
        HDR_ID1: r_id[47:32] <= {ioctl_data[7:0], ioctl_data[15:8]};
        HDR_ID2: r_id[31:16] <= {ioctl_data[7:0], ioctl_data[15:8]};
        HDR_ID3: r_id[15:0]  <= {ioctl_data[7:0], ioctl_data[15:8]};
        HDR_ID4: r_quirk     <= r_quirk | quirk_lookup({r_id, ioctl_data[7:0]});
        default: ;
      endcase
    end
  end

  assign ioctl_wait   = r_wait;
  assign wraddr       = r_wraddr;
  assign din          = r_din;
  assign we_req       = r_we_req;
  assign overflow     = r_overflow;
  assign sram_quirk   = r_quirk.sram;
  assign eeprom_quirk = r_quirk.eeprom;
  assign fifo_quirk   = r_quirk.fifo;
  assign zbus_quirk   = r_quirk.zbus;
  assign busy         = ~w_empty | (r_we_req != we_ack);

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - self-checking bench for rom_loader
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_data;
  logic        ioctl_wait;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic        sram_quirk, eeprom_quirk, fifo_quirk, zbus_quirk;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_writes = 0;
  int ack_delay = 3;
  int pend = 0;
  bit ack_hold = 0;
  bit mon_en = 0;
  logic prev_req = 1'b0;
  logic [40:0] sb[$];

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    logic [15:0] exp_din;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] hdr_fifo[5];
  logic [15:0] hdr_sram[5];

  rom_loader #(.DEPTH(4)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .wraddr         (wraddr),
    .din            (din),
    .we_req         (we_req),
    .we_ack         (we_ack),
    .sram_quirk     (sram_quirk),
    .eeprom_quirk   (eeprom_quirk),
    .fifo_quirk     (fifo_quirk),
    .zbus_quirk     (zbus_quirk),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Called at posedge+1; leaves ioctl_wr high for exactly one sampling edge
  task automatic push(input logic [24:0] a, input logic [15:0] d, input bit expect_wr);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    if (expect_wr) sb.push_back({a, d[7:0], d[15:8]});
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 200) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    chk(name, (n >= 200), 0);
  endtask

  // Write monitor (scoreboard pop) followed by the DDRAM ack responder
  initial begin
    logic [40:0] exp;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        if (we_req !== prev_req) begin
          prev_req = we_req;
          if (we_req !== we_ack) begin
            n_writes++;
            if (sb.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL unexpected_write: got wraddr=%0h din=%0h expected no write", wraddr, din);
            end else begin
              exp = sb.pop_front();
              chk("write_addr", 64'(wraddr), 64'(exp[40:16]));
              chk("write_din", 64'(din), 64'(exp[15:0]));
            end
          end
        end
        if (!ack_hold && we_req !== we_ack) begin
          pend++;
          if (pend >= ack_delay) begin
            we_ack = we_req;
            pend = 0;
          end
        end else begin
          pend = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    vecs[0] = '{25'h0000020, 16'hABCD, 16'hCDAB};
    vecs[1] = '{25'h1FFFFFE, 16'h00FF, 16'hFF00};
    vecs[2] = '{25'h0000000, 16'hFF00, 16'h00FF};
    vecs[3] = '{25'h00ABCDE, 16'h5AA5, 16'hA55A};
    hdr_fifo = '{16'h3020, 16'h3030, 16'h3130, 16'h3030, 16'h2D39};
    hdr_sram = '{16'h5420, 16'h302D, 16'h3138, 16'h3732, 16'h2036};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    we_ack = 1'b0;
    cycles(3);

    chk("rst_wait", 64'(ioctl_wait), 0);
    chk("rst_we_req", 64'(we_req), 0);
    chk("rst_wraddr", 64'(wraddr), 0);
    chk("rst_din", 64'(din), 0);
    chk("rst_quirks", 64'({zbus_quirk, fifo_quirk, eeprom_quirk, sram_quirk}), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_busy", 64'(busy), 0);
    reset = 1'b0;
    prev_req = we_req;
    mon_en = 1;

    // Single write with ack looped back after 3 cycles
    ioctl_download = 1'b1;
    cycles(1);
    push(25'h10, 16'h1234, 1);
    wait_idle("single_idle");
    chk("single_wraddr", 64'(wraddr), 64'h10);
    chk("single_din", 64'(din), 64'h3412);
    chk("single_writes", 64'(n_writes), 1);
    chk("single_busy", 64'(busy), 0);

    // Table of single writes covering byte-swap patterns and address extremes
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = vecs[i].addr;
      ioctl_data = vecs[i].data;
      sb.push_back({vecs[i].addr, vecs[i].exp_din});
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
      wait_idle("vec_idle");
      chk("vec_wraddr_hold", 64'(wraddr), 64'(vecs[i].addr));
      chk("vec_din_hold", 64'(din), 64'(vecs[i].exp_din));
    end
    chk("vec_writes", 64'(n_writes), 5);

    // Backpressure: one write outstanding, then 3 back-to-back pushes
    w0 = n_writes;
    ack_hold = 1;
    push(25'h100, 16'h0102, 1);
    cycles(2);
    push(25'h102, 16'h0304, 1);
    chk("bp_wait_1", 64'(ioctl_wait), 0);
    push(25'h104, 16'h0506, 1);
    chk("bp_wait_2", 64'(ioctl_wait), 0);
    push(25'h106, 16'h0708, 1);
    chk("bp_wait_3", 64'(ioctl_wait), 1);
    chk("bp_count", 64'(dut.u_fifo.count), 3);
    ack_hold = 0;
    wait_idle("bp_idle");
    chk("bp_writes", 64'(n_writes - w0), 4);
    chk("bp_wait_off", 64'(ioctl_wait), 0);

    // Overflow: write outstanding, 5 pushes ignoring ioctl_wait
    w0 = n_writes;
    ack_hold = 1;
    push(25'h200, 16'hA000, 1);
    cycles(2);
    push(25'h202, 16'hA001, 1);
    push(25'h204, 16'hA002, 1);
    push(25'h206, 16'hA003, 1);
    push(25'h208, 16'hA004, 1);
    push(25'h20A, 16'hDEAD, 0);
    chk("ovf_count", 64'(dut.u_fifo.count), 4);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_wait", 64'(ioctl_wait), 1);
    ack_hold = 0;
    wait_idle("ovf_idle");
    chk("ovf_writes", 64'(n_writes - w0), 5);
    chk("ovf_sticky", 64'(overflow), 1);

    // Header "00001009" after a restart
    ioctl_download = 1'b0;
    cycles(1);
    ioctl_download = 1'b1;
    cycles(1);
    chk("restart_ovf_clear", 64'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      push(25'h182 + 25'(2 * i), hdr_fifo[i], 1);
      if (i == 4) chk("hdr_fifo_quirk", 64'({zbus_quirk, fifo_quirk, eeprom_quirk, sram_quirk}), 64'b0100);
      wait_idle("hdr_idle");
    end
    ioctl_download = 1'b0;
    cycles(1);
    ioctl_download = 1'b1;
    cycles(1);
    chk("hdr_fifo_clear", 64'(fifo_quirk), 0);

    // Header "T-081276" sets sram only and holds after download ends
    for (int i = 0; i < 5; i++) begin
      push(25'h182 + 25'(2 * i), hdr_sram[i], 1);
      wait_idle("hdr2_idle");
    end
    chk("hdr_sram_quirk", 64'({zbus_quirk, fifo_quirk, eeprom_quirk, sram_quirk}), 64'b0001);
    ioctl_download = 1'b0;
    cycles(3);
    chk("hdr_sram_hold", 64'({zbus_quirk, fifo_quirk, eeprom_quirk, sram_quirk}), 64'b0001);

    // Abort: restart while a write is outstanding with we_ack=1, we_req=0
    ioctl_download = 1'b1;
    cycles(1);
    if (we_req) begin
      push(25'h40, 16'h1111, 1);
      wait_idle("abort_prep");
    end
    ack_hold = 1;
    we_ack = 1'b1;
    cycles(1);
    push(25'h50, 16'h2222, 0);
    push(25'h52, 16'h3333, 0);
    w0 = n_writes;
    ioctl_download = 1'b0;
    cycles(1);
    ioctl_download = 1'b1;
    cycles(1);
    chk("abort_we_req", 64'(we_req), 1);
    chk("abort_count", 64'(dut.u_fifo.count), 0);
    chk("abort_busy", 64'(busy), 0);
    cycles(2);
    chk("abort_no_write", 64'(n_writes - w0), 0);

    // Simultaneous push and drain at occupancy 2
    w0 = n_writes;
    push(25'h300, 16'hC000, 1);
    cycles(2);
    push(25'h302, 16'hC001, 1);
    push(25'h304, 16'hC002, 1);
    chk("sim_count_pre", 64'(dut.u_fifo.count), 2);
    we_ack = we_req;
    push(25'h306, 16'hC003, 1);
    chk("sim_count_post", 64'(dut.u_fifo.count), 2);
    chk("sim_wait", 64'(ioctl_wait), 0);
    ack_hold = 0;
    wait_idle("sim_idle");
    chk("sim_writes", 64'(n_writes - w0), 4);

    // ioctl_wr with download low is ignored
    ioctl_download = 1'b0;
    cycles(1);
    push(25'h400, 16'h4444, 0);
    cycles(3);
    chk("nodl_busy", 64'(busy), 0);
    chk("nodl_count", 64'(dut.u_fifo.count), 0);

    // Reset with a write outstanding
    ioctl_download = 1'b1;
    cycles(1);
    ack_hold = 1;
    push(25'h80, 16'hBEEF, 1);
    cycles(2);
    chk("midrst_busy_pre", 64'(busy), 1);
    reset = 1'b1;
    cycles(1);
    chk("midrst_we_req", 64'(we_req), 0);
    chk("midrst_wraddr", 64'(wraddr), 0);
    chk("midrst_din", 64'(din), 0);
    chk("midrst_wait", 64'(ioctl_wait), 0);
    chk("midrst_quirks", 64'({zbus_quirk, fifo_quirk, eeprom_quirk, sram_quirk}), 0);
    we_ack = 1'b0;
    cycles(1);
    chk("midrst_busy", 64'(busy), 0);
    reset = 1'b0;
    ack_hold = 0;
    cycles(3);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
